// File: rtl/dsp_pkg.sv
// Shared DSP helpers for the FIR interpolation/decimation chain.
package dsp_pkg;

  // Full-precision accumulator width for an n_taps dot product.
  function automatic int fir_out_width(input int in_w, input int coeff_w, input int n_taps);
    return in_w + coeff_w + $clog2(n_taps);
  endfunction

endpackage

// File: rtl/fir_decimator_if.sv
// Sample-stream bundle for fir_decimator: input samples, taps, flush and decimated output.
interface fir_decimator_if
  import dsp_pkg::*;
#(
  parameter int IN_W     = 16,
  parameter int COEFF_W  = 16,
  parameter int N_COEFFS = 5
);
  localparam int OUT_W = fir_out_width(IN_W, COEFF_W, N_COEFFS);

  logic                                clear;
  // Each COEFF_W slice is a signed tap; element 0 weights the newest sample.
  logic [N_COEFFS-1:0][COEFF_W-1:0]    coeff;
  logic signed [IN_W-1:0]              data_in;
  logic                                valid_in;
  logic signed [OUT_W-1:0]             data_out;
  logic                                valid_out;

  modport master (output clear, coeff, data_in, valid_in, input data_out, valid_out);
  modport slave  (input clear, coeff, data_in, valid_in, output data_out, valid_out);

endinterface

// File: rtl/fir_decimator_mac_tree.sv
// fir_mac_tree: combinational signed dot product of N samples with N coefficients.
module fir_mac_tree #(
  parameter int N        = 5,
  parameter int SAMPLE_W = 16,
  parameter int COEFF_W  = 16,
  parameter int OUT_W    = 35
) (
  input  logic [N-1:0][SAMPLE_W-1:0] samples,
  input  logic [N-1:0][COEFF_W-1:0]  coeffs,
  output logic signed [OUT_W-1:0]    acc
);

  logic signed [OUT_W-1:0] prod [N];

  // Operands are sign-extended to OUT_W first so every product is exact.
  for (genvar g = 0; g < N; g++) begin : g_prod
    assign prod[g] = OUT_W'($signed(samples[g])) * OUT_W'($signed(coeffs[g]));
  end

  always_comb begin
    acc = '0;
    for (int i = 0; i < N; i++) begin
      acc = acc + prod[i];
    end
  end

endmodule

// File: rtl/fir_decimator.sv
// Decimating FIR: shifts accepted samples into a delay line and emits one
// registered dot product every DECIM_FACTOR accepted inputs.
module fir_decimator
  import dsp_pkg::*;
#(
  parameter int INPUT_WORD_SIZE = 16,
  parameter int COEFF_WORD_SIZE = 16,
  parameter int N_COEFFS        = 5,
  parameter int DECIM_FACTOR    = 2
) (
  input logic           clk,
  input logic           arst_n,
  fir_decimator_if.slave bus
);

  localparam int OUTPUT_WORD_SIZE = fir_out_width(INPUT_WORD_SIZE, COEFF_WORD_SIZE, N_COEFFS);
  localparam int PH_W = (DECIM_FACTOR > 1) ? $clog2(DECIM_FACTOR) : 1;
  localparam logic [PH_W-1:0] LAST_PHASE = PH_W'(DECIM_FACTOR - 1);

  logic [N_COEFFS-2:0][INPUT_WORD_SIZE-1:0] dline;
  logic [PH_W-1:0]                          phase;
  logic signed [OUTPUT_WORD_SIZE-1:0]       mac;
  logic signed [OUTPUT_WORD_SIZE-1:0]       data_out_q;
  logic                                     valid_out_q;
  logic                                     decim_now;

  // Tap 0 is the incoming sample, so the result uses the pre-shift delay line.
  fir_mac_tree #(
    .N        (N_COEFFS),
    .SAMPLE_W (INPUT_WORD_SIZE),
    .COEFF_W  (COEFF_WORD_SIZE),
    .OUT_W    (OUTPUT_WORD_SIZE)
  ) u_mac (
    .samples ({dline, bus.data_in}),
    .coeffs  (bus.coeff),
    .acc     (mac)
  );

  assign decim_now = bus.valid_in && (phase == LAST_PHASE);

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      dline       <= '0;
      phase       <= '0;
      data_out_q  <= '0;
      valid_out_q <= 1'b0;
    end else if (bus.clear) begin
      dline       <= '0;
      phase       <= '0;
      valid_out_q <= 1'b0;
    end else begin
      valid_out_q <= 1'b0;
      if (bus.valid_in) begin
        dline[0] <= bus.data_in;
        for (int i = 1; i < N_COEFFS - 1; i++) begin
          dline[i] <= dline[i-1];
        end
        phase <= (phase == LAST_PHASE) ? '0 : phase + 1'b1;
      end
      if (decim_now) begin
        data_out_q  <= mac;
        valid_out_q <= 1'b1;
      end
    end
  end

  assign bus.data_out  = data_out_q;
  assign bus.valid_out = valid_out_q;

endmodule

// File: tb/tb_fir_decimator.sv
// Scoreboard bench for fir_decimator: M=2 instance for the stream tests, M=1 instance for extremes.
module tb_fir_decimator;
  import dsp_pkg::*;

  logic clk = 1'b0;
  logic arst_n = 1'b0;
  always #5 clk = ~clk;

  fir_decimator_if #(.IN_W(16), .COEFF_W(16), .N_COEFFS(5)) if_a ();
  fir_decimator_if #(.IN_W(16), .COEFF_W(16), .N_COEFFS(5)) if_b ();

  fir_decimator #(.INPUT_WORD_SIZE(16), .COEFF_WORD_SIZE(16), .N_COEFFS(5), .DECIM_FACTOR(2))
    dut_a (.clk(clk), .arst_n(arst_n), .bus(if_a.slave));
  fir_decimator #(.INPUT_WORD_SIZE(16), .COEFF_WORD_SIZE(16), .N_COEFFS(5), .DECIM_FACTOR(1))
    dut_b (.clk(clk), .arst_n(arst_n), .bus(if_b.slave));

  int     n_checks = 0;
  int     n_fail   = 0;
  longint exp_a[$];
  longint exp_b[$];
  longint imp_exp [3] = '{2, 4, 0};
  longint dc_exp  [3] = '{200000, 400000, 500000};

  task automatic check(input string name, input longint got, input longint want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  // Monitors: every valid_out must follow an accepted input and match the queue head.
  initial begin : mon_a
    logic acc;
    forever begin
      @(posedge clk);
      acc = if_a.valid_in && !if_a.clear && arst_n;
      @(negedge clk);
      if (if_a.valid_out) begin
        check("a_valid_after_accept", longint'(acc), 1);
        if (exp_a.size() == 0) check("a_unexpected_output", longint'(if_a.data_out), -1);
        else check("a_data_out", longint'(if_a.data_out), exp_a.pop_front());
      end
    end
  end

  initial begin : mon_b
    logic acc;
    forever begin
      @(posedge clk);
      acc = if_b.valid_in && !if_b.clear && arst_n;
      @(negedge clk);
      if (if_b.valid_out) begin
        check("b_valid_after_accept", longint'(acc), 1);
        if (exp_b.size() == 0) check("b_unexpected_output", longint'(if_b.data_out), -1);
        else check("b_data_out", longint'(if_b.data_out), exp_b.pop_front());
      end
    end
  end

  task automatic send_a(input logic signed [15:0] d, input int gap, input logic clr);
    repeat (gap) begin
      @(negedge clk);
      if_a.valid_in = 1'b0;
      if_a.clear    = 1'b0;
    end
    @(negedge clk);
    if_a.data_in  = d;
    if_a.valid_in = 1'b1;
    if_a.clear    = clr;
  endtask

  task automatic idle_a(input int n);
    repeat (n) begin
      @(negedge clk);
      if_a.valid_in = 1'b0;
      if_a.clear    = 1'b0;
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    if_a.clear = 1'b0; if_a.valid_in = 1'b0; if_a.data_in = '0; if_a.coeff = '0;
    if_b.clear = 1'b0; if_b.valid_in = 1'b0; if_b.data_in = '0; if_b.coeff = '0;
    #1;
    check("reset_a_data_out",  longint'(if_a.data_out),  0);
    check("reset_a_valid_out", longint'(if_a.valid_out), 0);
    check("reset_b_data_out",  longint'(if_b.data_out),  0);
    check("reset_b_valid_out", longint'(if_b.valid_out), 0);
    repeat (2) @(negedge clk);
    arst_n = 1'b1;

    // Impulse, gapless then gapped: outputs 2, 4, 0 on accepted inputs 2, 4, 6.
    for (int i = 0; i < 5; i++) if_a.coeff[i] = 16'(i + 1);
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 6; i++) begin
        send_a((i == 0) ? 16'sd1 : 16'sd0, (pass == 0) ? 0 : int'($urandom_range(0, 3)), 1'b0);
        if (i % 2 == 1) exp_a.push_back(imp_exp[i/2]);
      end
      idle_a(3);
    end

    // DC fill: 100 * 1000 over a filling 5-tap line.
    for (int i = 0; i < 5; i++) if_a.coeff[i] = 16'sd1000;
    for (int i = 0; i < 8; i++) begin
      send_a(16'sd100, 0, 1'b0);
      if (i % 2 == 1) exp_a.push_back((i < 6) ? dc_exp[i/2] : 64'sd500000);
    end
    idle_a(3);

    // clear mid-stream: flush, 3 samples, clear+valid dropped, 2 fresh samples.
    @(negedge clk); if_a.clear = 1'b1;
    idle_a(1);
    for (int i = 0; i < 3; i++) begin
      send_a(16'sd100, 0, 1'b0);
      if (i == 1) exp_a.push_back(200000);
    end
    send_a(16'sd100, 0, 1'b1);
    send_a(16'sd100, 0, 1'b0);
    send_a(16'sd100, 0, 1'b0);
    exp_a.push_back(200000);
    idle_a(3);

    // Async reset between decimation instants.
    send_a(16'sd100, 0, 1'b0);
    idle_a(1);
    @(posedge clk);
    #3 arst_n = 1'b0;
    #1;
    check("async_reset_data_out",  longint'(if_a.data_out),  0);
    check("async_reset_valid_out", longint'(if_a.valid_out), 0);
    @(negedge clk);
    arst_n = 1'b1;
    send_a(16'sd100, 0, 1'b0);
    send_a(16'sd100, 0, 1'b0);
    exp_a.push_back(200000);
    idle_a(3);

    // Extreme negative on the M=1 instance: k * 2^30 while the line fills.
    for (int i = 0; i < 5; i++) if_b.coeff[i] = 16'h8000;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      if_b.data_in  = 16'sh8000;
      if_b.valid_in = 1'b1;
      exp_b.push_back(64'sd1073741824 * longint'((i < 5) ? i + 1 : 5));
    end
    @(negedge clk);
    if_b.valid_in = 1'b0;

    repeat (6) @(negedge clk);
    check("a_queue_drained", longint'(exp_a.size()), 0);
    check("b_queue_drained", longint'(exp_b.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
